// File: rtl/decode_pkg.sv
// decode_pkg: instruction formats, opcodes and the entry record shared by the decode stage
package decode_pkg;
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_NONE = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        fmt_t        fmt;
    } entry_t;

    localparam entry_t ENTRY_RST = '{pc: 32'd0, instr: 32'd0, imm: 32'd0, fmt: FMT_NONE};
endpackage

// File: rtl/imm_format_decode.sv
// imm_format_decode: classifies an instruction word and extracts its 32-bit immediate
module imm_format_decode
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm,
    output fmt_t        o_fmt
);
    logic [6:0] w_op;
    logic [2:0] w_f3;
    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    always_comb begin
        o_imm = '0;
        o_fmt = FMT_NONE;
        case (w_op)
            OP_IMM: begin
                o_fmt = (w_f3 == 3'b001 || w_f3 == 3'b101) ? FMT_SH : FMT_I;
                o_imm = (o_fmt == FMT_SH) ? {27'd0, i_instr[24:20]} : {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OP_LOAD, OP_JALR: begin
                o_fmt = FMT_I;
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OP_STORE: begin
                o_fmt = FMT_S;
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = {i_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                o_fmt = FMT_J;
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            OP_REG: o_fmt = FMT_R;
            default: o_fmt = FMT_NONE;
        endcase
    end
endmodule

// File: rtl/decode_imm_stage.sv
// decode_imm_stage: registered decode stage with a 2-entry skid buffer, flush and stall counter
module decode_imm_stage
    import decode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_pc,
    input  logic [31:0]      i_in_instr,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_pc,
    output logic [31:0]      o_out_instr,
    output logic [31:0]      o_out_imm,
    output fmt_t             o_out_fmt,
    output logic [CNT_W-1:0] o_stall_cnt
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           r_state, w_next;
    entry_t           r_head, r_skid, w_in;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall;
    logic [31:0]      w_imm;
    fmt_t             w_fmt;
    logic             w_accept, w_pop, w_load_in, w_load_skid, w_skid_to_head;

    imm_format_decode u_dec (.i_instr(i_in_instr), .o_imm(w_imm), .o_fmt(w_fmt));

    assign w_in        = '{pc: i_in_pc, instr: i_in_instr, imm: w_imm, fmt: w_fmt};
    assign w_accept    = i_in_valid & r_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = (r_state != S_EMPTY);
    assign o_out_pc    = r_head.pc;
    assign o_out_instr = r_head.instr;
    assign o_out_imm   = r_head.imm;
    assign o_out_fmt   = r_head.fmt;
    assign o_stall_cnt = r_stall;

    // Head takes the input when empty or when it is popped while a new entry arrives
    assign w_load_in      = !i_flush && w_accept && (r_state == S_EMPTY || (r_state == S_ONE && w_pop));
    assign w_load_skid    = !i_flush && w_accept && r_state == S_ONE && !w_pop;
    assign w_skid_to_head = !i_flush && r_state == S_TWO && w_pop;

    always_comb begin
        w_next = r_state;
        if (i_flush)
            w_next = S_EMPTY;
        else
            case (r_state)
                S_EMPTY: w_next = w_accept ? S_ONE : S_EMPTY;
                S_ONE:   w_next = (w_accept && !w_pop) ? S_TWO : (w_pop && !w_accept) ? S_EMPTY : S_ONE;
                S_TWO:   w_next = w_pop ? S_ONE : S_TWO;
                default: w_next = S_EMPTY;
            endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_head     <= ENTRY_RST;
            r_skid     <= ENTRY_RST;
            r_stall    <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != S_TWO);
            if (w_load_in)
                r_head <= w_in;
            else if (w_skid_to_head)
                r_head <= r_skid;
            if (w_load_skid)
                r_skid <= w_in;
            if (o_out_valid && !i_out_ready && r_stall != '1)
                r_stall <= r_stall + CNT_W'(1);
        end
    end
endmodule
